// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared widths, FSM encoding and address-field helpers for the
//               direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = CPU_ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_WRITEBACK = 2'd1;
    localparam state_t S_MEM_READ  = 2'd2;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [CPU_ADDR_W-1:0] addr);
        return addr[CPU_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_store
// Description : Valid/dirty/tag/data line arrays with byte-write and block-fill
//               ports and combinational read of the indexed line.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_store #(
    parameter int LINES  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(LINES),
    parameter int SEL_W  = $clog2(DATA_W / 8)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [IDX_W-1:0]  i_index,
    input  logic              i_byte_we,
    input  logic [SEL_W-1:0]  i_byte_sel,
    input  logic [7:0]        i_byte_data,
    input  logic              i_fill_we,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_clean,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data
);

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Only the status bits are reset; tag/data contents are don't-care until valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_byte_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_clean) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (i_fill_we) begin
                r_tag[i_index]  <= i_fill_tag;
                r_data[i_index] <= i_fill_data;
            end else if (i_byte_we) begin
                r_data[i_index][{i_byte_sel, 3'b000} +: 8] <= i_byte_data;
            end
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-back, write-allocate data cache between
//               the 8-bit CPU data port and a block-wide data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import dcache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int ADDR_W      = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    state_t              r_state;
    state_t              w_next_state;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_req;
    logic                w_hit;
    logic                w_rd_hit;
    logic                w_byte_we;
    logic                w_fill_we;
    logic                w_clean;
    logic [7:0]          w_rd_byte;
    logic [7:0]          r_readdata;

    logic                   s_valid;
    logic                   s_dirty;
    logic [TAG_W-1:0]       s_tag;
    logic [BLOCK_BYTES*8-1:0] s_data;

    assign w_tag    = addr_tag(ADDRESS);
    assign w_index  = addr_index(ADDRESS);
    assign w_offset = addr_offset(ADDRESS);
    assign w_req    = READ | WRITE;
    assign w_hit    = s_valid & (s_tag == w_tag);

    dcache_store #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .DATA_W (BLOCK_BYTES * 8)
    ) u_store (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_index     (w_index),
        .i_byte_we   (w_byte_we),
        .i_byte_sel  (w_offset),
        .i_byte_data (WRITEDATA),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (mem_readdata),
        .i_clean     (w_clean),
        .o_valid     (s_valid),
        .o_dirty     (s_dirty),
        .o_tag       (s_tag),
        .o_data      (s_data)
    );

    always_comb begin
        w_next_state = r_state;
        w_byte_we    = 1'b0;
        w_fill_we    = 1'b0;
        w_clean      = 1'b0;
        BUSYWAIT     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = {w_tag, w_index};
        case (r_state)
            S_IDLE: begin
                BUSYWAIT  = w_req & ~w_hit;
                w_byte_we = WRITE & w_hit;
                if (w_req && !w_hit)
                    w_next_state = (s_valid && s_dirty) ? S_WRITEBACK : S_MEM_READ;
            end
            S_WRITEBACK: begin
                BUSYWAIT    = 1'b1;
                mem_write   = 1'b1;
                mem_address = {s_tag, w_index};
                if (!mem_busywait) begin
                    w_clean      = 1'b1;
                    w_next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                BUSYWAIT = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    w_fill_we    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign mem_writedata = s_data;

    // A simultaneous READ/WRITE is a store, so it never updates the load result.
    assign w_rd_hit  = (r_state == S_IDLE) & READ & ~WRITE & w_hit;
    assign w_rd_byte = s_data[{w_offset, 3'b000} +: 8];
    assign READDATA  = w_rd_hit ? w_rd_byte : r_readdata;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_readdata <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_rd_hit)
                r_readdata <= w_rd_byte;
        end
    end

endmodule
`default_nettype wire
